// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the HI/LO divide controller.
// No logic; pure declarations.
// No flow control.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Reset is active-low, so "reset asserted" compares against 0.
    localparam logic RstEnable         = 1'b0;
    localparam logic WriteEnable       = 1'b1;
    localparam logic WriteDisable      = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D.
// Purely combinational, zero latency.
// No flow control.
module div_ctrl_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    // One extra bit above the shifted remainder so the trial sign is exact.
    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] trial;
    logic             neg;

    assign r_sh  = {r, q[WIDTH-1]};
    assign trial = r_sh - {1'b0, d};
    assign neg   = trial[WIDTH+1];

    assign r_next = neg ? r_sh[WIDTH:0] : trial[WIDTH:0];
    assign q_next = {q[WIDTH-2:0], ~neg};

endmodule

// File: rtl/div_ctrl.sv
// Iterative DIV/DIVU controller: remainder to HI, quotient to LO.
// Latency 33 cycles (2 for divide-by-zero) from request to HI/LO write.
// Stalls the pipeline while busy; annul_i aborts without writing HI/LO.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e       state, state_nx;
    logic [CW-1:0]    cnt;
    logic             sgn_q, s1_q, s2_q;
    logic [WIDTH:0]   r_q, d_q, r_nx;
    logic [WIDTH-1:0] q_q, q_nx;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] mag1, mag2, lo_fix, hi_fix, dz_hi;
    logic             req;

    assign req  = (start_i == DivStart) && (annul_i == DivStop);
    assign mag1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    div_ctrl_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_nx),
        .q_next (q_nx)
    );

    // Sign fixup applied to the final iteration's result.
    assign lo_fix = (sgn_q && (s1_q != s2_q)) ? -q_nx : q_nx;
    assign hi_fix = (sgn_q && s1_q) ? -r_nx[WIDTH-1:0] : r_nx[WIDTH-1:0];
    // Q still holds the dividend magnitude; re-negating restores the raw value.
    assign dz_hi  = (sgn_q && s1_q) ? -q_q : q_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) state <= DivFree;
        else                  state <= state_nx;
    end

    // Next-state and handshake outputs; reset and annul suppress the write.
    always_comb begin
        state_nx  = state;
        stall_o   = 1'b0;
        ready_o   = DivResultNotReady;
        hilo_we_o = WriteDisable;
        case (state)
            DivFree: begin
                if (req) begin
                    stall_o  = 1'b1;
                    state_nx = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                stall_o  = 1'b1;
                state_nx = annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                stall_o = 1'b1;
                if (annul_i)          state_nx = DivFree;
                else if (cnt == LAST) state_nx = DivEnd;
            end
            DivEnd: begin
                state_nx = DivFree;
                if (!annul_i) begin
                    ready_o   = DivResultReady;
                    hilo_we_o = WriteEnable;
                end
            end
            default: state_nx = DivFree;
        endcase
        if (rst == RstEnable) begin
            state_nx  = DivFree;
            stall_o   = 1'b0;
            ready_o   = DivResultNotReady;
            hilo_we_o = WriteDisable;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt   <= '0;
            sgn_q <= 1'b0;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            r_q   <= '0;
            d_q   <= '0;
            q_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                DivFree: begin
                    if (req) begin
                        sgn_q <= signed_i;
                        s1_q  <= opdata1_i[WIDTH-1];
                        s2_q  <= opdata2_i[WIDTH-1];
                        d_q   <= {1'b0, mag2};
                        q_q   <= mag1;
                        r_q   <= '0;
                        cnt   <= '0;
                    end
                end
                DivByZero: begin
                    if (!annul_i) begin
                        lo_q <= '1;
                        hi_q <= dz_hi;
                    end
                end
                DivOn: begin
                    if (!annul_i) begin
                        r_q <= r_nx;
                        q_q <= q_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            lo_q <= lo_fix;
                            hi_q <= hi_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
